mem_access: RTL
===============

// Module: mem_access
// PURPOSE
//  MEM stage of the miniRV pipeline. Takes EX/MEM values, drives the DRAM req/ack port with lane-aligned
//  store data and byte mask, extends load data, and registers the MEM/WB bundle consumed by writeback.
//  Stalls upstream while a DRAM access is outstanding; non-memory instructions pass in one cycle.
// PARAMETERS
//  TIMEOUT   15   max WAIT cycles without dram_ack before forced completion (err)
//  RST_PC4   0    reset value of mem_wb_pc4
// PORTS
//  clk              in   1   clock, rising edge
//  rst_n            in   1   async reset, active low
//  ex_mem_valid     in   1   EX/MEM slot holds an instruction
//  ex_mem_rd        in   1   load;  ex_mem_wr in 1 store (never both)
//  ex_mem_funct3    in   3   width/sign: 000 B,001 H,010 W,100 BU,101 HU
//  ex_mem_ALU_C     in   32  ALU result / effective address
//  ex_mem_rD2       in   32  store data
//  ex_mem_pc4, ex_mem_imm_ext in 32; ex_mem_rf_wsel in 2; ex_mem_rf_we in 1; ex_mem_wR in 5
//  dram_req         out  1   access request;  dram_we out 1 write strobe
//  dram_addr        out  32  {ALU_C[31:2],2'b00};  dram_wmask out 4 byte lanes
//  dram_wdin        out  32  lane-replicated store data;  dram_rdo in 32 read word
//  dram_ack         in   1   access done (read data valid this cycle)
//  mem_stall        out  1   upstream must hold EX/MEM
//  mem_wb_valid, mem_wb_rf_we out 1; mem_wb_wR out 5; mem_wb_rf_wsel out 2
//  mem_wb_pc4, mem_wb_ALU_C, mem_wb_DRAM_rdo, mem_wb_imm_ext  out 32
//  mem_wb_err       out  1   access timed out (or misaligned, see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE, all mem_wb_* 0 (pc4=RST_PC4), timeout counter 0; dram_*/mem_stall 0.
//  FSM IDLE/WAIT. acc = ex_mem_valid & (rd|wr).
//   IDLE: acc -> dram_req=1 combinationally; ack same cycle -> retire, stay IDLE; else -> WAIT.
//   WAIT: dram_req=1, addr/we/wmask/wdin from held EX/MEM; ack -> retire, IDLE;
//         cnt==TIMEOUT -> retire with rdo=0, err=1, IDLE (no ack wait beyond).
//   !acc & ex_mem_valid: retire in 1 cycle. !ex_mem_valid: mem_wb_valid<=0, rf_we<=0.
//  mem_stall = dram_req & ~dram_ack & ~timeout_hit. Retire = posedge load of all mem_wb_*.
//  While stalled mem_wb_* hold previous values; mem_wb_valid=0 during stall cycles (bubble).
//  Store: SB mask=1<<a[1:0], wdin={4{rD2[7:0]}}; SH mask=3<<{a[1],1'b0}, wdin={2{rD2[15:0]}};
//         SW mask=4'hF, wdin=rD2. dram_we=wr. Loads: mask=0, we=0.
//  Load: select byte a[1:0] / half a[1] of dram_rdo; B,H sign-extend; BU,HU zero-extend; W raw.
//  mem_wb_DRAM_rdo = extended load data, 0 for non-loads. Other fields copied from EX/MEM.
//  Counter cleared on entering WAIT; saturates; ack and timeout same cycle -> ack wins, err=0.
//  Reset mid-access: immediate abort, dram_req drops asynchronously, no retire.
//  Unsupported funct3 on memory op: treated as W.
// CONFIGURATION
//  MEM_MISALIGN_CHK_EN defined: H with a[0]=1 or W with a[1:0]!=0 -> no dram_req,
//    retire in 1 cycle with rf_we=0, err=1, DRAM_rdo=0.
//  Undefined: low address bits ignored for H/W (half uses a[1], word uses word address); err only on timeout.
// TESTING
//  LW a=0x10, ack same cycle, rdo=0x8765_4321 -> no stall, next cycle mem_wb_DRAM_rdo=0x87654321, valid=1.
//  LB a=0x13, rdo=0x80xx_xxxx -> 0xFFFFFF80; LBU same -> 0x00000080; LH a=0x12 -> sign-ext rdo[31:16].
//  SB a=0x21 rD2=0xAB, ack after 3 cycles -> mask=0010, wdin=0xABABABAB, mem_stall high 3 cycles.
//  Load, ack never -> stall TIMEOUT+1 cycles then retire err=1, DRAM_rdo=0, FSM back to IDLE.
//  Non-memory op wsel=ALU, ALU_C=5 -> 1-cycle retire, dram_req=0; rst_n low in WAIT -> req 0, outputs reset.
//  MEM_MISALIGN_CHK_EN: LW a=0x02 -> no dram_req, err=1, rf_we=0; disabled -> word 0x00 read.

Source files
------------

// File: rtl/mem_access_if.sv
// DRAM request/acknowledge port of the miniRV MEM stage.
// master = memory stage (issues requests), slave = DRAM or its model.
interface mem_access_if;
    logic        dram_req;
    logic        dram_we;
    logic [31:0] dram_addr;
    logic [3:0]  dram_wmask;
    logic [31:0] dram_wdin;
    logic [31:0] dram_rdo;
    logic        dram_ack;

    modport master (
        output dram_req, dram_we, dram_addr, dram_wmask, dram_wdin,
        input  dram_rdo, dram_ack
    );

    modport slave (
        input  dram_req, dram_we, dram_addr, dram_wmask, dram_wdin,
        output dram_rdo, dram_ack
    );
endinterface

// File: rtl/mem_access.sv
// miniRV MEM stage: DRAM req/ack access with lane alignment, load extension, MEM/WB register.
// Optional macro MEM_MISALIGN_CHK_EN: misaligned H/W accesses retire at once with err and no DRAM request.
module mem_access #(
    parameter int unsigned TIMEOUT = 15,
    parameter logic [31:0] RST_PC4 = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ex_mem_valid_i,
    input  logic         ex_mem_rd_i,
    input  logic         ex_mem_wr_i,
    input  logic [2:0]   ex_mem_funct3_i,
    input  logic [31:0]  ex_mem_ALU_C_i,
    input  logic [31:0]  ex_mem_rD2_i,
    input  logic [31:0]  ex_mem_pc4_i,
    input  logic [31:0]  ex_mem_imm_ext_i,
    input  logic [1:0]   ex_mem_rf_wsel_i,
    input  logic         ex_mem_rf_we_i,
    input  logic [4:0]   ex_mem_wR_i,
    mem_access_if.master dram,
    output logic         mem_stall_o,
    output logic         mem_wb_valid_o,
    output logic         mem_wb_rf_we_o,
    output logic [4:0]   mem_wb_wR_o,
    output logic [1:0]   mem_wb_rf_wsel_o,
    output logic [31:0]  mem_wb_pc4_o,
    output logic [31:0]  mem_wb_ALU_C_o,
    output logic [31:0]  mem_wb_DRAM_rdo_o,
    output logic [31:0]  mem_wb_imm_ext_o,
    output logic         mem_wb_err_o
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        valid_q, rf_we_q, err_q;
    logic [4:0]  wR_q;
    logic [1:0]  wsel_q;
    logic [31:0] pc4_q, alu_q, rdo_q, imm_q;

    logic        is_byte, is_half, misalign, acc, req, timeout_hit;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [3:0]  st_mask;
    logic [31:0] st_data;

    // BU/HU encodings only mean byte/half for loads; on stores they fall back to word
    assign is_byte = (ex_mem_funct3_i == 3'b000) || (ex_mem_rd_i && ex_mem_funct3_i == 3'b100);
    assign is_half = (ex_mem_funct3_i == 3'b001) || (ex_mem_rd_i && ex_mem_funct3_i == 3'b101);

`ifdef MEM_MISALIGN_CHK_EN
    assign misalign = ex_mem_valid_i && (ex_mem_rd_i || ex_mem_wr_i) &&
                      (is_half ? ex_mem_ALU_C_i[0] : (!is_byte && ex_mem_ALU_C_i[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign acc         = ex_mem_valid_i && (ex_mem_rd_i || ex_mem_wr_i) && !misalign;
    assign req         = acc && rst_n;
    assign timeout_hit = (state_q == S_WAIT) && (cnt_q == CW'(TIMEOUT));
    assign mem_stall_o = req && !dram.dram_ack && !timeout_hit;

    always_comb begin
        st_mask = 4'hF;
        st_data = ex_mem_rD2_i;
        if (is_byte) begin
            st_mask = 4'b0001 << ex_mem_ALU_C_i[1:0];
            st_data = {4{ex_mem_rD2_i[7:0]}};
        end else if (is_half) begin
            st_mask = ex_mem_ALU_C_i[1] ? 4'b1100 : 4'b0011;
            st_data = {2{ex_mem_rD2_i[15:0]}};
        end
    end

    assign dram.dram_req   = req;
    assign dram.dram_we    = req && ex_mem_wr_i;
    assign dram.dram_addr  = req ? {ex_mem_ALU_C_i[31:2], 2'b00} : '0;
    assign dram.dram_wmask = (req && ex_mem_wr_i) ? st_mask : '0;
    assign dram.dram_wdin  = (req && ex_mem_wr_i) ? st_data : '0;

    always_comb begin
        case (ex_mem_ALU_C_i[1:0])
            2'b00:   ld_byte = dram.dram_rdo[7:0];
            2'b01:   ld_byte = dram.dram_rdo[15:8];
            2'b10:   ld_byte = dram.dram_rdo[23:16];
            default: ld_byte = dram.dram_rdo[31:24];
        endcase
        ld_half = ex_mem_ALU_C_i[1] ? dram.dram_rdo[31:16] : dram.dram_rdo[15:0];
        case (ex_mem_funct3_i)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = dram.dram_rdo;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (acc && !dram.dram_ack) begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            default: begin
                if (!acc || dram.dram_ack || timeout_hit) state_d = S_IDLE;
                else if (cnt_q != CW'(TIMEOUT))           cnt_d   = cnt_q + CW'(1);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            rf_we_q <= 1'b0;
            err_q   <= 1'b0;
            wR_q    <= '0;
            wsel_q  <= '0;
            pc4_q   <= RST_PC4;
            alu_q   <= '0;
            rdo_q   <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!ex_mem_valid_i) begin
                valid_q <= 1'b0;
                rf_we_q <= 1'b0;
            end else if (mem_stall_o) begin
                valid_q <= 1'b0;
            end else begin
                // an unstalled access without ack can only be a timeout
                valid_q <= 1'b1;
                rf_we_q <= ex_mem_rf_we_i && !misalign;
                err_q   <= misalign || (acc && !dram.dram_ack);
                wR_q    <= ex_mem_wR_i;
                wsel_q  <= ex_mem_rf_wsel_i;
                pc4_q   <= ex_mem_pc4_i;
                alu_q   <= ex_mem_ALU_C_i;
                imm_q   <= ex_mem_imm_ext_i;
                rdo_q   <= (acc && ex_mem_rd_i && dram.dram_ack) ? ld_data : '0;
            end
        end
    end

    assign mem_wb_valid_o    = valid_q;
    assign mem_wb_rf_we_o    = rf_we_q;
    assign mem_wb_wR_o       = wR_q;
    assign mem_wb_rf_wsel_o  = wsel_q;
    assign mem_wb_pc4_o      = pc4_q;
    assign mem_wb_ALU_C_o    = alu_q;
    assign mem_wb_DRAM_rdo_o = rdo_q;
    assign mem_wb_imm_ext_o  = imm_q;
    assign mem_wb_err_o      = err_q;
endmodule
